// File: rtl/forw_ctrl.sv
// forw_ctrl: forwarding / load-use hazard controller for the integer pipeline.
// Tracks destination tags of the instructions in EX, MEM and WB and, for the
// instruction leaving ID, registers the operand forwarding selects it will
// use in EX. Detects load-use hazards (one-cycle stall with bubble insertion)
// and counts stall cycles with saturation.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source register indices
//   id_uses_rs, id_uses_rt     ID instruction reads rs / rt
//   id_rd, id_regwrite         ID destination and write enable
//   id_memread                 ID instruction is a load
//   flush                      kill the ID instruction
//   sel_rs, sel_rt             registered forwarding selects for EX
//                              (00 bank, 01 EX, 10 MEM, 11 WB producer)
//   stall                      combinational stall request (hold PC, IF/ID)
//   stall_cnt                  saturating stall-cycle counter
module forw_ctrl #(
  parameter int REGBITS = 5,
  parameter int SELBITS = 2,
  parameter int CNTBITS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               flush,
  output logic [SELBITS-1:0] sel_rs,
  output logic [SELBITS-1:0] sel_rt,
  output logic               stall,
  output logic [CNTBITS-1:0] stall_cnt
);

  typedef struct packed {
    logic               valid;
    logic [REGBITS-1:0] rd;
    logic               regwrite;
    logic               memread;
  } tag_t;

  tag_t tex, tmem, twb;

  logic               load_ex;
  logic [SELBITS-1:0] nxt_rs, nxt_rt;

  function automatic logic hit(tag_t t, logic [REGBITS-1:0] s);
    return t.valid & t.regwrite & (t.rd == s) & (s != '0);
  endfunction

  // Nearest producer wins: EX before MEM before WB.
  function automatic logic [SELBITS-1:0] pick(tag_t e, tag_t m, tag_t w,
                                              logic used,
                                              logic [REGBITS-1:0] s);
    if (!used)        return '0;
    if (hit(e, s))    return SELBITS'(1);
    if (hit(m, s))    return SELBITS'(2);
    if (hit(w, s))    return SELBITS'(3);
    return '0;
  endfunction

  // Stall is gated by reset so stale tags cannot request a stall while the
  // pipeline is being cleared.
  always_comb begin
    stall = ~reset & id_valid & ~flush & tex.valid & tex.memread &
            tex.regwrite & (tex.rd != '0) &
            ((id_uses_rs & (id_rs == tex.rd)) |
             (id_uses_rt & (id_rt == tex.rd)));
    load_ex = id_valid & ~flush & ~stall;
    nxt_rs  = pick(tex, tmem, twb, id_uses_rs, id_rs);
    nxt_rt  = pick(tex, tmem, twb, id_uses_rt, id_rt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tex       <= '0;
      tmem      <= '0;
      twb       <= '0;
      sel_rs    <= '0;
      sel_rt    <= '0;
      stall_cnt <= '0;
    end else begin
      twb  <= tmem;
      tmem <= tex;
      if (load_ex) begin
        tex    <= '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite,
                    memread: id_memread};
        sel_rs <= nxt_rs;
        sel_rt <= nxt_rt;
      end else begin
        // Bubble: nothing to forward to, selects point at the bank.
        tex    <= '0;
        sel_rs <= '0;
        sel_rt <= '0;
      end
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_forw_ctrl.sv
module tb_forw_ctrl;

  logic       clk = 1'b0;
  logic       reset, id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
  logic [4:0] id_rs, id_rt, id_rd;
  logic [1:0] sel_rs, sel_rt, sel_rs2, sel_rt2;
  logic       stall, stall2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  always #5 clk = ~clk;

  forw_ctrl #(.REGBITS(5), .SELBITS(2), .CNTBITS(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .sel_rs(sel_rs), .sel_rt(sel_rt), .stall(stall), .stall_cnt(stall_cnt));

  // Narrow-counter instance for saturation; shares all stimulus.
  forw_ctrl #(.REGBITS(5), .SELBITS(2), .CNTBITS(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .sel_rs(sel_rs2), .sel_rt(sel_rt2), .stall(stall2), .stall_cnt(stall_cnt2));

  // Reference model: list of the instructions issued into EX over the last
  // three cycles (index 0 = EX, 1 = MEM, 2 = WB).
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t pipe[3];
  int   exp_rs, exp_rt, stalls;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int src_sel(input bit used, input int s);
    if (!used || s == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (pipe[k].v && pipe[k].rw && pipe[k].rd == s) return k + 1;
    return 0;
  endfunction

  // One clock: drive at negedge, check stall, advance model at posedge,
  // check registered outputs at the following negedge.
  task automatic cyc(input bit rst, input bit v, input int rs, input int rt,
                     input bit urs, input bit urt, input int rd, input bit rw,
                     input bit mr, input bit fl, output bit st);
    bit   est, issue;
    int   nrs, nrt;
    ins_t ni;
    reset = rst; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
    id_uses_rs = urs; id_uses_rt = urt; id_rd = 5'(rd);
    id_regwrite = rw; id_memread = mr; flush = fl;
    #1;
    est = !rst && v && !fl && pipe[0].v && pipe[0].mr && pipe[0].rw &&
          pipe[0].rd != 0 && ((urs && rs == pipe[0].rd) || (urt && rt == pipe[0].rd));
    chk("stall", int'(stall), int'(est));
    chk("stall_w2", int'(stall2), int'(est));
    st = stall;
    issue = v && !est && !fl;
    nrs = issue ? src_sel(urs, rs) : 0;
    nrt = issue ? src_sel(urt, rt) : 0;
    ni.v = issue; ni.rd = issue ? rd : 0; ni.rw = issue && rw; ni.mr = issue && mr;
    @(posedge clk);
    if (rst) begin
      foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0};
      exp_rs = 0; exp_rt = 0; stalls = 0;
    end else begin
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = ni;
      exp_rs = nrs; exp_rt = nrt;
      if (est) stalls++;
    end
    @(negedge clk);
    chk("sel_rs", int'(sel_rs), exp_rs);
    chk("sel_rt", int'(sel_rt), exp_rt);
    chk("stall_cnt", int'(stall_cnt), (stalls > 65535) ? 65535 : stalls);
    chk("stall_cnt_w2", int'(stall_cnt2), (stalls > 3) ? 3 : stalls);
  endtask

  // Shorthands: ALU op, load, independent filler.
  task automatic alu(input int rs, input int rt, input int rd, output bit st);
    cyc(0, 1, rs, rt, 1, 1, rd, 1, 0, 0, st);
  endtask
  task automatic lw(input int rs, input int rd, output bit st);
    cyc(0, 1, rs, 0, 1, 0, rd, 1, 1, 0, st);
  endtask

  bit st;
  bit [1:0] sat_exp [4];

  initial begin
    foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0};
    exp_rs = 0; exp_rt = 0; stalls = 0;
    sat_exp[0] = 2'd2; sat_exp[1] = 2'd3; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3;
    @(negedge clk);

    // Reset for two cycles.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    cyc(1, 1, 3, 3, 1, 1, 3, 1, 1, 0, st);
    chk("rst_sel_rs", int'(sel_rs), 0);
    chk("rst_sel_rt", int'(sel_rt), 0);
    chk("rst_stall", int'(st), 0);
    chk("rst_cnt", int'(stall_cnt), 0);

    // ALU chain with 0..3 independent instructions between producer and reader.
    alu(1, 2, 3, st);
    alu(3, 4, 20, st);
    chk("alu_d1_rs", int'(sel_rs), 1);
    chk("alu_d1_rt", int'(sel_rt), 0);
    alu(1, 2, 3, st); alu(10, 11, 12, st);
    alu(3, 4, 20, st);
    chk("alu_d2_rs", int'(sel_rs), 2);
    alu(1, 2, 3, st); alu(10, 11, 12, st); alu(10, 11, 13, st);
    alu(3, 4, 20, st);
    chk("alu_d3_rs", int'(sel_rs), 3);
    alu(1, 2, 3, st); alu(10, 11, 12, st); alu(10, 11, 13, st); alu(10, 11, 14, st);
    alu(3, 4, 20, st);
    chk("alu_d4_rs", int'(sel_rs), 0);

    // Nearest producer wins.
    alu(1, 2, 5, st); alu(6, 6, 5, st);
    alu(5, 5, 21, st);
    chk("prio_rs", int'(sel_rs), 1);
    chk("prio_rt", int'(sel_rt), 1);

    // Load-use: one stall cycle, bubble, then MEM forward.
    lw(1, 7, st);
    alu(8, 7, 22, st);
    chk("lu_stall", int'(st), 1);
    chk("lu_bubble_rs", int'(sel_rs), 0);
    chk("lu_bubble_rt", int'(sel_rt), 0);
    chk("lu_cnt", int'(stall_cnt), 1);
    alu(8, 7, 22, st);
    chk("lu_nostall", int'(st), 0);
    chk("lu_sel_rt", int'(sel_rt), 2);

    // Register zero never forwarded nor stalled on.
    alu(1, 2, 0, st);
    alu(0, 0, 23, st);
    chk("r0_rs", int'(sel_rs), 0);
    chk("r0_rt", int'(sel_rt), 0);
    lw(1, 0, st);
    alu(0, 0, 23, st);
    chk("r0_lw_stall", int'(st), 0);

    // Flushed dependent: no stall, and its own rd is never tracked.
    lw(1, 7, st);
    cyc(0, 1, 7, 7, 1, 1, 8, 1, 0, 1, st);
    chk("fl_stall", int'(st), 0);
    alu(8, 7, 24, st);
    chk("fl_rs", int'(sel_rs), 0);
    chk("fl_rt", int'(sel_rt), 2);

    // Saturation of the 2-bit counter over four more load-use stalls.
    for (int i = 0; i < 4; i++) begin
      lw(1, 9, st);
      alu(9, 2, 25, st);
      chk("sat_cnt_w2", int'(stall_cnt2), int'(sat_exp[i]));
      alu(9, 2, 25, st);
    end

    // Randomized traffic over a small register range, with occasional
    // reset and flush.
    for (int n = 0; n < 3000; n++) begin
      bit r, v, urs, urt, rw, mr, fl;
      r   = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 9) != 0);
      urs = $urandom_range(0, 1);
      urt = $urandom_range(0, 1);
      mr  = ($urandom_range(0, 2) == 0);
      rw  = mr ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 9) == 0);
      cyc(r, v, $urandom_range(0, 7), $urandom_range(0, 7), urs, urt,
          $urandom_range(0, 7), rw, mr, fl, st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/forw_ctrl.md
# forw_ctrl

Forwarding and hazard controller for the integer pipeline. It tracks the destination registers of the instructions in EX, MEM and WB. For the instruction leaving ID, it computes the registered `sel_addr` values that drive the two operand forwarding muxes in EX, one for rs and one for rt. It also detects load-use hazards, requests a one-cycle stall with bubble insertion, and keeps a saturating count of stall cycles.

## Interface

Parameters:
- `REGBITS`, 5, register index width.
- `SELBITS`, 2, forwarding mux select width.
- `CNTBITS`, 16, stall counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous reset, active-high.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  REGBITS  source register indices of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  in  1  ID instruction reads rs / rt.
- `id_rd`  in  REGBITS  destination index of the ID instruction.
- `id_regwrite`  in  1  ID instruction writes `id_rd`.
- `id_memread`  in  1  ID instruction is a load.
- `flush`  in  1  kill the ID instruction (taken branch/jump).
- `sel_rs`, `sel_rt`  out  SELBITS  forwarding selects for the instruction now in EX (registered).
- `stall`  out  1  hold PC and IF/ID this cycle (combinational).
- `stall_cnt`  out  CNTBITS  saturating count of stall cycles.

## Operation

Select encoding (matches `forw_mux`):
- 00: register bank.
- 01: alustg (producer one ahead).
- 10: memstg (two ahead).
- 11: wbstg (three ahead).

Tag pipeline:
- Three tag registers, TEX, TMEM and TWB. Each tag holds {valid, rd, regwrite, memread}.
- On every clock: TWB←TMEM, TMEM←TEX.
- TEX←ID fields when `id_valid & ~stall & ~flush`; otherwise TEX←bubble (all zero).

Producer match:
- Tag T matches source s when T.valid & T.regwrite & T.rd==s & s!=0.

Select for source s (only when that source is used; otherwise 00), computed at ID:
- 01 if TEX matches.
- else 10 if TMEM matches.
- else 11 if TWB matches.
- else 00.
- Nearest producer wins.

Select registers:
- `sel_rs` and `sel_rt` load the computed values on the same edge that loads TEX with the ID instruction.
- When TEX loads a bubble, both selects load 00.

Load-use stall:
- `stall` = `id_valid & ~flush & TEX.valid & TEX.memread & TEX.regwrite & TEX.rd!=0 & ((id_uses_rs & id_rs==TEX.rd) | (id_uses_rt & id_rt==TEX.rd))`.
- A stall lasts exactly one cycle. On the next cycle the load is in TMEM, the same ID instruction re-evaluates, and it gets select 10.

Flush:
- `flush` has priority over `stall`.
- A flushed ID instruction is never tracked.

Counter:
- `stall_cnt` increments by 1 on each clock with `stall`=1.
- It holds at all-ones.

## Timing

- Reset (`reset`=1 at a rising edge) clears:
  - all tags invalid;
  - `sel_rs`=`sel_rt`=00;
  - `stall_cnt`=0.
- `stall` is 0 during and after reset until a load is tracked.
- Reset mid-operation discards all in-flight tags. No forwarding is produced from instructions issued before reset.
- Select latency: selects computed in cycle N from ID are visible in cycle N+1, while the instruction is in EX.
- `stall` is combinational from registered tags and the current ID inputs, and is valid within the same cycle.
- Back-to-back loads, each used by its successor, produce one stall per load, never two consecutive stalls for the same instruction.
- An rs and rt hazard on the same load causes a single stall.
- When rs==rt, both selects are identical.
- A destination of 0 is never forwarded or stalled on.
- A producer with `regwrite`=0 (store or branch) is never matched.

## Test plan

1. Reset: with `reset`=1 for 2 cycles → `sel_rs`=`sel_rt`=00, `stall`=0, `stall_cnt`=0.
2. ALU chain: `add r3` then `sub` using rs=r3 → `sel_rs`=01 in the sub's EX cycle and `sel_rt`=00. With one independent instruction between them → `sel_rs`=10. With two between → `sel_rs`=11. With three between → `sel_rs`=00.
3. Priority: `add r5`, `or r5`, then a reader using rs=r5 and rt=r5 → both selects 01 (the nearer `or` wins).
4. Load-use: `lw r7` then `add` using rt=r7 → `stall`=1 for exactly one cycle, EX gets a bubble with selects 00, then `sel_rt`=10 for the add, and `stall_cnt` reaches 1.
5. Zero register and flush:
   - producer with rd=r0 → selects 00, no stall;
   - `lw r7` followed by a dependent instruction with `flush`=1 → `stall`=0 and the flushed instruction's tag is never forwarded from.
6. Saturation: `CNTBITS`=2 with 5 load-use stalls → `stall_cnt` goes 1, 2, 3, then holds at 3.
